// File: rtl/halflife_decay_counter.sv
// halflife_decay_counter: up/down counter whose value halves every period+1 cycles while decay is enabled.
module halflife_decay_counter #(
  parameter int N    = 8,
  parameter int PW   = 8,
  parameter int WRAP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_i,
  input  logic          down_i,
  input  logic          load_i,
  input  logic          decay_en_i,
  input  logic [N-1:0]  in_i,
  input  logic [PW-1:0] period_i,
  output logic [N-1:0]  out_o,
  output logic          tick_o,
  output logic          lim_o,
  output logic [3:0]    halvings_o,
  output logic          zero_o
);
  logic [N-1:0]  out_q, out_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    hv_q, hv_d;
  logic          tick_q, tick_d, lim_q, lim_d;
  logic          cnt, decay, hit, at_lim;
  always_comb begin
    cnt    = up_i ^ down_i;
    decay  = decay_en_i && (out_q != '0);
    hit    = pre_q == period_i;
    at_lim = up_i ? (out_q == '1) : (out_q == '0);
    out_d  = out_q;
    pre_d  = '0;
    hv_d   = hv_q;
    tick_d = 1'b0;
    lim_d  = 1'b0;
    if (load_i) begin
      out_d = in_i;
      hv_d  = '0;
    end else if (cnt) begin
      lim_d = at_lim;
      out_d = (at_lim && WRAP == 0) ? out_q : (up_i ? out_q + 1'b1 : out_q - 1'b1);
    end else if (decay) begin
      // prescaler free-runs modulo 2^PW, so a period shrunk below it waits for the wrap
      pre_d  = hit ? '0 : pre_q + 1'b1;
      out_d  = hit ? out_q >> 1 : out_q;
      tick_d = hit;
      hv_d   = (hit && hv_q != 4'hF) ? hv_q + 4'd1 : hv_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      pre_q  <= '0;
      hv_q   <= '0;
      tick_q <= 1'b0;
      lim_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      pre_q  <= pre_d;
      hv_q   <= hv_d;
      tick_q <= tick_d;
      lim_q  <= lim_d;
    end
  end
  assign out_o      = out_q;
  assign tick_o     = tick_q;
  assign lim_o      = lim_q;
  assign halvings_o = hv_q;
  assign zero_o     = out_q == '0;
endmodule

// File: tb/tb_halflife_decay_counter.sv
// tb_halflife_decay_counter: directed spec scenarios plus randomized run against an arithmetic model, saturate and wrap builds side by side.
module tb_halflife_decay_counter;
  logic       clk = 1'b0, rst = 1'b1, up = 1'b0, down = 1'b0, load = 1'b0, decay_en = 1'b0;
  logic [7:0] in_v = '0, period = '0;
  logic [7:0] out0, out1;
  logic       tick0, tick1, lim0, lim1, zero0, zero1;
  logic [3:0] hv0, hv1;
  int m_out[2], m_pre[2], m_hv[2];
  bit m_tick[2], m_lim[2];
  int n_chk = 0, n_fail = 0;

  halflife_decay_counter #(.N(8), .PW(8), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .up_i(up), .down_i(down), .load_i(load), .decay_en_i(decay_en),
    .in_i(in_v), .period_i(period), .out_o(out0), .tick_o(tick0), .lim_o(lim0),
    .halvings_o(hv0), .zero_o(zero0));
  halflife_decay_counter #(.N(8), .PW(8), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .up_i(up), .down_i(down), .load_i(load), .decay_en_i(decay_en),
    .in_i(in_v), .period_i(period), .out_o(out1), .tick_o(tick1), .lim_o(lim1),
    .halvings_o(hv1), .zero_o(zero1));

  always #5 clk = ~clk;

  task automatic model_update();
    for (int w = 0; w < 2; w++) begin
      m_tick[w] = 0;
      m_lim[w]  = 0;
      if (rst) begin
        m_out[w] = 0; m_pre[w] = 0; m_hv[w] = 0;
      end else if (load) begin
        m_out[w] = int'(in_v); m_hv[w] = 0; m_pre[w] = 0;
      end else if (up != down) begin
        m_pre[w] = 0;
        if (up && m_out[w] == 255) begin
          m_lim[w] = 1;
          if (w == 1) m_out[w] = 0;
        end else if (down && m_out[w] == 0) begin
          m_lim[w] = 1;
          if (w == 1) m_out[w] = 255;
        end else m_out[w] = up ? m_out[w] + 1 : m_out[w] - 1;
      end else if (decay_en && m_out[w] != 0) begin
        if (m_pre[w] == int'(period)) begin
          m_out[w] = m_out[w] / 2;
          m_pre[w] = 0;
          m_tick[w] = 1;
          if (m_hv[w] < 15) m_hv[w] = m_hv[w] + 1;
        end else m_pre[w] = (m_pre[w] + 1) % 256;
      end else m_pre[w] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; up = 0; down = 0; load = 0; decay_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; up = 1; load = 1; in_v = 8'h33; decay_en = 1;
    step(); step();
    n_chk++;
    if (out0 !== 8'h00 || hv0 !== 4'd0 || tick0 !== 1'b0 || lim0 !== 1'b0 || zero0 !== 1'b1 || out1 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset got out0=%h hv0=%0d tick0=%b lim0=%b zero0=%b out1=%h exp 00/0/0/0/1/00",
               out0, hv0, tick0, lim0, zero0, out1);
    end
    idle();
  endtask

  task automatic test_decay_seq();
    logic [7:0] exp_o;
    logic [3:0] exp_h;
    logic       exp_t;
    idle(); period = 8'd3; decay_en = 1; load = 1; in_v = 8'h80;
    step(); load = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_o = 8'h80 >> (k / 4);
      exp_t = (k % 4 == 0) && (k <= 32);
      exp_h = 4'((k / 4 > 8) ? 8 : k / 4);
      n_chk++;
      if (out0 !== exp_o || tick0 !== exp_t || hv0 !== exp_h) begin
        n_fail++;
        $display("FAIL decay_seq k=%0d got out=%h tick=%b hv=%0d exp out=%h tick=%b hv=%0d",
                 k, out0, tick0, hv0, exp_o, exp_t, exp_h);
      end
    end
  endtask

  task automatic test_limits();
    idle(); load = 1; in_v = 8'hFF; step(); load = 0;
    up = 1; step(); up = 0;
    n_chk++;
    if (out0 !== 8'hFF || lim0 !== 1'b1 || out1 !== 8'h00 || lim1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lim_up got sat=%h/%b wrap=%h/%b exp FF/1 00/1", out0, lim0, out1, lim1);
    end
    step();
    n_chk++;
    if (out0 !== 8'hFF || lim0 !== 1'b0 || out1 !== 8'h00 || lim1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lim_drop got sat=%h/%b wrap=%h/%b exp FF/0 00/0", out0, lim0, out1, lim1);
    end
    load = 1; in_v = 8'h00; step(); load = 0;
    down = 1; step(); down = 0;
    n_chk++;
    if (out0 !== 8'h00 || lim0 !== 1'b1 || zero0 !== 1'b1 || out1 !== 8'hFF || lim1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lim_down got sat=%h/%b/z%b wrap=%h/%b exp 00/1/z1 FF/1", out0, lim0, zero0, out1, lim1);
    end
  endtask

  task automatic test_count_clears_prescaler();
    idle(); period = 8'd2; decay_en = 1; load = 1; in_v = 8'h40; step(); load = 0;
    step();
    up = 1; step(); up = 0;
    n_chk++;
    if (out0 !== 8'h41 || tick0 !== 1'b0 || hv0 !== 4'd0) begin
      n_fail++;
      $display("FAIL up_in_decay got out=%h tick=%b hv=%0d exp 41/0/0", out0, tick0, hv0);
    end
    step(); step();
    n_chk++;
    if (out0 !== 8'h41 || tick0 !== 1'b0) begin
      n_fail++;
      $display("FAIL presc_cleared got out=%h tick=%b exp 41/0", out0, tick0);
    end
    step();
    n_chk++;
    if (out0 !== 8'h20 || tick0 !== 1'b1 || hv0 !== 4'd1) begin
      n_fail++;
      $display("FAIL tick_after_up got out=%h tick=%b hv=%0d exp 20/1/1", out0, tick0, hv0);
    end
  endtask

  task automatic test_priority();
    idle(); decay_en = 1; period = 8'd0; load = 1; up = 1; in_v = 8'h05;
    step(); load = 0; up = 0;
    n_chk++;
    if (out0 !== 8'h05 || hv0 !== 4'd0 || lim0 !== 1'b0 || tick0 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_prio got out=%h hv=%0d lim=%b tick=%b exp 05/0/0/0", out0, hv0, lim0, tick0);
    end
    period = 8'd5; step(); step();
    rst = 1; load = 1; in_v = 8'h09; step(); rst = 0; load = 0;
    n_chk++;
    if (out0 !== 8'h00 || hv0 !== 4'd0 || tick0 !== 1'b0 || zero0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_prio got out=%h hv=%0d tick=%b zero=%b exp 00/0/0/1", out0, hv0, tick0, zero0);
    end
    period = 8'd2; up = 1; step(); up = 0;
    step(); step();
    n_chk++;
    if (out0 !== 8'h01 || tick0 !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_wait got out=%h tick=%b exp 01/0", out0, tick0);
    end
    step();
    n_chk++;
    if (out0 !== 8'h00 || tick0 !== 1'b1 || hv0 !== 4'd1) begin
      n_fail++;
      $display("FAIL resume_tick got out=%h tick=%b hv=%0d exp 00/1/1", out0, tick0, hv0);
    end
  endtask

  task automatic test_period_zero();
    idle(); period = 8'd0; decay_en = 1; load = 1; in_v = 8'hFF; step(); load = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 8 || k == 20) begin
        n_chk++;
        if (out0 !== 8'h00 || hv0 !== 4'd8 || tick0 !== (k == 8)) begin
          n_fail++;
          $display("FAIL period0 k=%0d got out=%h hv=%0d tick=%b exp 00/8/%b", k, out0, hv0, tick0, k == 8);
        end
      end
    end
    decay_en = 0; load = 1; in_v = 8'h10; step(); load = 0;
    up = 1; down = 1; step();
    n_chk++;
    if (out0 !== 8'h10 || lim0 !== 1'b0 || tick0 !== 1'b0) begin
      n_fail++;
      $display("FAIL updown_hold got out=%h lim=%b tick=%b exp 10/0/0", out0, lim0, tick0);
    end
    decay_en = 1; step(); up = 0; down = 0;
    n_chk++;
    if (out0 !== 8'h08 || tick0 !== 1'b1) begin
      n_fail++;
      $display("FAIL updown_decay got out=%h tick=%b exp 08/1", out0, tick0);
    end
  endtask

  task automatic test_period_change();
    int edges;
    idle(); period = 8'd7; decay_en = 1; load = 1; in_v = 8'h80; step(); load = 0;
    repeat (5) step();
    period = 8'd2;
    edges = 0;
    do begin
      step();
      edges++;
    end while (tick0 !== 1'b1 && edges < 300);
    n_chk++;
    if (edges != 254 || out0 !== 8'h40) begin
      n_fail++;
      $display("FAIL period_shrink got edges=%0d out=%h exp 254/40", edges, out0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      rst      = $urandom_range(99) == 0;
      load     = $urandom_range(19) == 0;
      up       = $urandom_range(5) == 0;
      down     = $urandom_range(5) == 0;
      decay_en = $urandom_range(3) != 0;
      in_v     = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(49) == 0) period = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom_range(6));
      step();
      n_chk++;
      if ({out0, tick0, lim0, hv0, zero0} !== {8'(m_out[0]), m_tick[0], m_lim[0], 4'(m_hv[0]), m_out[0] == 0}) begin
        n_fail++;
        $display("FAIL rand_sat c=%0d got out=%h t=%b l=%b hv=%0d z=%b exp out=%h t=%b l=%b hv=%0d",
                 c, out0, tick0, lim0, hv0, zero0, 8'(m_out[0]), m_tick[0], m_lim[0], m_hv[0]);
      end
      n_chk++;
      if ({out1, tick1, lim1, hv1, zero1} !== {8'(m_out[1]), m_tick[1], m_lim[1], 4'(m_hv[1]), m_out[1] == 0}) begin
        n_fail++;
        $display("FAIL rand_wrap c=%0d got out=%h t=%b l=%b hv=%0d z=%b exp out=%h t=%b l=%b hv=%0d",
                 c, out1, tick1, lim1, hv1, zero1, 8'(m_out[1]), m_tick[1], m_lim[1], m_hv[1]);
      end
      n_chk++;
      if ((tick0 && lim0) || (tick1 && lim1)) begin
        n_fail++;
        $display("FAIL tick_lim_excl c=%0d got sat=%b%b wrap=%b%b exp not both", c, tick0, lim0, tick1, lim1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decay_seq();
    test_limits();
    test_count_clears_prescaler();
    test_priority();
    test_period_zero();
    test_period_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
